change_dispenser: RTL and testbench

- Downstream of the vending-machine controller `vm`; this block consumes `vm`'s `refund`/`refundall` strobes and its `balance` value.
- Pays the amount out as physical coins (50, 20 and 10 sen), one at a time, using fixed-width eject pulses.
- Keeps per-denomination coin stock counters and reports short change.
- Exposes its FSM state for debug.

---
 rtl/change_dispenser.sv | 135 +++++++++++++
 tb/tb_change_dispenser.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 50/20/10 sen coin payout with stock tracking
module change_dispenser #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int STOCK_INIT   = 20,
    parameter int LOW_MARK     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refund,
    input  logic       refundall,
    input  logic [9:0] amount,
    input  logic       restock,
    output logic       coin50,
    output logic       coin20,
    output logic       coin10,
    output logic       busy,
    output logic       done,
    output logic       shortfall,
    output logic [9:0] remaining,
    output logic       low_stock,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {D_NONE, D_50, D_20, D_10} denom_t;

    localparam logic [7:0] INIT_VAL   = 8'(STOCK_INIT);
    localparam logic [7:0] LOW_VAL    = 8'(LOW_MARK);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t     cur, nxt;
    denom_t     sel, pick;
    logic [3:0] cnt;
    logic [7:0] stock50, stock20, stock10;
    logic       strobe;

    assign strobe = refund | refundall;

    // Greedy pick: largest coin that fits and is still in stock.
    always_comb begin
        pick = D_NONE;
        if (remaining >= 10'd50 && stock50 != 8'd0)
            pick = D_50;
        else if (remaining >= 10'd20 && stock20 != 8'd0)
            pick = D_20;
        else if (remaining >= 10'd10 && stock10 != 8'd0)
            pick = D_10;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   if (strobe) nxt = S_SELECT;
            S_SELECT: nxt = (pick != D_NONE) ? S_EJECT : S_DONE;
            S_EJECT:  if (cnt == PULSE_LAST) nxt = S_GAP;
            S_GAP:    if (cnt == GAP_LAST) nxt = S_SELECT;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur       <= S_IDLE;
            sel       <= D_NONE;
            cnt       <= 4'd0;
            remaining <= 10'd0;
            shortfall <= 1'b0;
            stock50   <= INIT_VAL;
            stock20   <= INIT_VAL;
            stock10   <= INIT_VAL;
        end else begin
            cur <= nxt;
            case (cur)
                S_IDLE: begin
                    if (strobe) begin
                        remaining <= amount;
                        shortfall <= 1'b0;
                    end else if (restock) begin
                        stock50 <= INIT_VAL;
                        stock20 <= INIT_VAL;
                        stock10 <= INIT_VAL;
                    end
                end
                S_SELECT: begin
                    sel <= pick;
                    cnt <= 4'd0;
                    if (pick == D_NONE && remaining != 10'd0)
                        shortfall <= 1'b1;
                end
                S_EJECT: begin
                    // Account for the coin once, on the first pulse clock.
                    if (cnt == 4'd0) begin
                        case (sel)
                            D_50: begin
                                remaining <= remaining - 10'd50;
                                stock50   <= stock50 - 8'd1;
                            end
                            D_20: begin
                                remaining <= remaining - 10'd20;
                                stock20   <= stock20 - 8'd1;
                            end
                            D_10: begin
                                remaining <= remaining - 10'd10;
                                stock10   <= stock10 - 8'd1;
                            end
                            default: ;
                        endcase
                    end
                    cnt <= (cnt == PULSE_LAST) ? 4'd0 : cnt + 4'd1;
                end
                S_GAP: cnt <= (cnt == GAP_LAST) ? 4'd0 : cnt + 4'd1;
                default: ;
            endcase
        end
    end

    assign coin50    = (cur == S_EJECT) && (sel == D_50);
    assign coin20    = (cur == S_EJECT) && (sel == D_20);
    assign coin10    = (cur == S_EJECT) && (sel == D_10);
    assign busy      = (cur != S_IDLE);
    assign done      = (cur == S_DONE);
    assign state     = cur;
    assign low_stock = (stock50 < LOW_VAL) || (stock20 < LOW_VAL) || (stock10 < LOW_VAL);

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser
module tb_change_dispenser;

    localparam int PULSE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       refund = 1'b0;
    logic       refundall = 1'b0;
    logic [9:0] amount = 10'd0;
    logic       restock = 1'b0;
    logic       coin50, coin20, coin10, busy, done, shortfall, low_stock;
    logic [9:0] remaining;
    logic [2:0] state;

    change_dispenser dut (
        .clk(clk), .rst(rst), .refund(refund), .refundall(refundall),
        .amount(amount), .restock(restock), .coin50(coin50), .coin20(coin20),
        .coin10(coin10), .busy(busy), .done(done), .shortfall(shortfall),
        .remaining(remaining), .low_stock(low_stock), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed coin pulses encoded as denom*100 + width.
    int obs_q[$];
    int exp_q[$];
    int rd_idx = 0;
    int done_cnt = 0;
    int multi_hot = 0;
    int cur_d = 0;
    int cur_w = 0;

    always @(negedge clk) begin
        if (int'(coin50) + int'(coin20) + int'(coin10) > 1) multi_hot++;
        if (done) done_cnt++;
        if (coin50 | coin20 | coin10) begin
            if (cur_w == 0) cur_d = coin50 ? 50 : (coin20 ? 20 : 10);
            cur_w++;
        end else if (cur_w != 0) begin
            obs_q.push_back(cur_d * 100 + cur_w);
            cur_w = 0;
        end
    end

    int m_s50 = 20, m_s20 = 20, m_s10 = 20;
    int m_rem = 0;
    int m_sf = 0;
    int exp_done = 0;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_pay(input int amt);
        m_rem = amt;
        forever begin
            if (m_rem >= 50 && m_s50 > 0) begin m_rem -= 50; m_s50--; exp_q.push_back(50 * 100 + PULSE); end
            else if (m_rem >= 20 && m_s20 > 0) begin m_rem -= 20; m_s20--; exp_q.push_back(20 * 100 + PULSE); end
            else if (m_rem >= 10 && m_s10 > 0) begin m_rem -= 10; m_s10--; exp_q.push_back(10 * 100 + PULSE); end
            else break;
        end
        m_sf = (m_rem != 0) ? 1 : 0;
        exp_done++;
    endtask

    task automatic start(input int amt, input bit all, input bit with_restock);
        model_pay(amt);
        amount    = 10'(amt);
        refund    = !all;
        refundall = all;
        restock   = with_restock;
        @(posedge clk); #1;
        refund    = 1'b0;
        refundall = 1'b0;
        restock   = 1'b0;
    endtask

    task automatic do_restock();
        restock = 1'b1;
        @(posedge clk); #1;
        restock = 1'b0;
        m_s50 = 20; m_s20 = 20; m_s10 = 20;
    endtask

    task automatic finish_check(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".idle"}, int'(busy), 0);
        @(posedge clk); #1;
        check({tag, ".ncoins"}, obs_q.size() - rd_idx, exp_q.size());
        while (exp_q.size() > 0 && rd_idx < obs_q.size()) begin
            check({tag, ".coin"}, obs_q[rd_idx], exp_q.pop_front());
            rd_idx++;
        end
        exp_q.delete();
        rd_idx = obs_q.size();
        check({tag, ".remaining"}, int'(remaining), m_rem);
        check({tag, ".shortfall"}, int'(shortfall), m_sf);
        check({tag, ".low_stock"}, int'(low_stock), (m_s50 < 5 || m_s20 < 5 || m_s10 < 5) ? 1 : 0);
        check({tag, ".stock50"}, int'(dut.stock50), m_s50);
        check({tag, ".stock20"}, int'(dut.stock20), m_s20);
        check({tag, ".stock10"}, int'(dut.stock10), m_s10);
        check({tag, ".done_cnt"}, done_cnt, exp_done);
    endtask

    initial begin
        logic [4:0] got, want;
        int n;

        #12;
        check("reset.state", int'(state), 0);
        check("reset.outs", int'({coin50, coin20, coin10, busy, done, shortfall}), 0);
        check("reset.remaining", int'(remaining), 0);
        check("reset.low_stock", int'(low_stock), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // 80 sen: cycle-accurate trace; index e is the spec edge number.
        start(80, 1'b0, 1'b0);
        for (int e = 1; e <= 18; e++) begin
            got  = {busy, coin50, coin20, coin10, done};
            want = {e <= 17, e == 2 || e == 3, e == 7 || e == 8, e == 12 || e == 13, e == 17};
            check($sformatf("p80.cycle%0d", e), int'(got), int'(want));
            if (e < 18) begin @(posedge clk); #1; end
        end
        finish_check("p80");

        // zero amount through the cancel path: done two cycles after strobe
        start(0, 1'b1, 1'b0);
        check("p0.busy", int'(busy), 1);
        @(posedge clk); #1;
        check("p0.done", int'(done), 1);
        finish_check("p0");

        start(75, 1'b0, 1'b0);
        finish_check("p75");

        do_restock();
        check("restock.low_stock", int'(low_stock), 0);

        for (int i = 0; i < 21; i++) begin
            start(10, 1'b0, 1'b0);
            finish_check($sformatf("drain%0d", i));
        end

        start(60, 1'b0, 1'b0);
        finish_check("greedy60");

        // strobe and restock during a payout must be ignored
        start(80, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        amount = 10'd30; refund = 1'b1; restock = 1'b1;
        @(posedge clk); #1;
        refund = 1'b0; restock = 1'b0;
        finish_check("busyignore");

        // strobe wins over restock in the same cycle
        start(20, 1'b0, 1'b1);
        finish_check("samecycle");

        do_restock();
        check("restock2.low_stock", int'(low_stock), 0);
        check("restock2.stock10", int'(dut.stock10), 20);

        // async reset during an eject pulse
        start(50, 1'b0, 1'b0);
        n = 0;
        while (!coin50 && n < 20) begin @(posedge clk); #1; n++; end
        check("rstmid.coin50_seen", int'(coin50), 1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("rstmid.coin50", int'(coin50), 0);
        check("rstmid.state", int'(state), 0);
        check("rstmid.remaining", int'(remaining), 0);
        check("rstmid.stocks", int'(dut.stock50) + int'(dut.stock20) + int'(dut.stock10), 60);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        rd_idx = obs_q.size();

        check("onehot", multi_hot, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
